// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register file sizing constants
package rf_pkg;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int NREG     = 2**AW;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-destination scoreboard with three lookups
module reg_scoreboard #(
  parameter int AW = rf_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_idx,
  input  logic [AW-1:0] look_idx1,
  input  logic [AW-1:0] look_idx2,
  input  logic [AW-1:0] look_idx3,
  output logic          look_pend1,
  output logic          look_pend2,
  output logic          look_pend3
);
  import rf_pkg::*;

  localparam int            NR       = 2**AW;
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic [NR-1:0] pending_q;
  logic [NR-1:0] pending_d;
  logic [NR-1:0] set_mask;
  logic [NR-1:0] clr_mask;
  logic [NR-1:0] pend_eff;

  // x0 never enters or leaves the scoreboard; set is applied after clear so it wins.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en && (clr_idx != ZERO_IDX)) clr_mask[clr_idx] = 1'b1;
    if (set_en && (set_idx != ZERO_IDX)) set_mask[set_idx] = 1'b1;
    pend_eff  = pending_q & ~clr_mask;
    pending_d = pend_eff | set_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign look_pend1 = pend_eff[look_idx1];
  assign look_pend2 = pend_eff[look_idx2];
  assign look_pend3 = pend_eff[look_idx3];
endmodule

// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - operand read, bypass, hazard stall and output register
module operand_fetch #(
  parameter int XLEN    = rf_pkg::XLEN,
  parameter int AW      = rf_pkg::AW,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      in_rs1,
  input  logic [AW-1:0]      in_rs2,
  input  logic [AW-1:0]      in_rd,
  input  logic               in_rd_we,
  output logic [AW-1:0]      rf_raddr1,
  output logic [AW-1:0]      rf_raddr2,
  input  logic [XLEN-1:0]    rf_rdata1,
  input  logic [XLEN-1:0]    rf_rdata2,
  input  logic               wb_we,
  input  logic [AW-1:0]      wb_waddr,
  input  logic [XLEN-1:0]    wb_wdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_op1,
  output logic [XLEN-1:0]    out_op2,
  output logic [AW-1:0]      out_rd,
  output logic               out_rd_we,
  output logic [STALL_W-1:0] stall_cnt
);
  import rf_pkg::*;

  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

  logic               pend_rs1;
  logic               pend_rs2;
  logic               pend_rd;
  logic               hazard;
  logic               accept;
  logic [XLEN-1:0]    op1_sel;
  logic [XLEN-1:0]    op2_sel;

  logic               out_valid_q, out_valid_d;
  logic [XLEN-1:0]    out_op1_q,   out_op1_d;
  logic [XLEN-1:0]    out_op2_q,   out_op2_d;
  logic [AW-1:0]      out_rd_q,    out_rd_d;
  logic               out_rd_we_q, out_rd_we_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [XLEN-1:0] sel_operand(
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] rdata,
    input logic            byp_we,
    input logic [AW-1:0]   byp_addr,
    input logic [XLEN-1:0] byp_data
  );
    if (rs == ZERO_IDX) return '0;
    else if (byp_we && (byp_addr == rs)) return byp_data;
    else return rdata;
  endfunction

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  reg_scoreboard #(.AW(AW)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (accept & in_rd_we),
    .set_idx    (in_rd),
    .clr_en     (wb_we),
    .clr_idx    (wb_waddr),
    .look_idx1  (in_rs1),
    .look_idx2  (in_rs2),
    .look_idx3  (in_rd),
    .look_pend1 (pend_rs1),
    .look_pend2 (pend_rs2),
    .look_pend3 (pend_rd)
  );

  // A same-cycle writeback has already been removed from the lookups, so it never stalls.
  assign hazard   = pend_rs1 | pend_rs2 | (in_rd_we & pend_rd);
  assign in_ready = ~hazard & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  assign op1_sel = sel_operand(in_rs1, rf_rdata1, wb_we, wb_waddr, wb_wdata);
  assign op2_sel = sel_operand(in_rs2, rf_rdata2, wb_we, wb_waddr, wb_wdata);

  always_comb begin
    out_valid_d = out_valid_q;
    out_op1_d   = out_op1_q;
    out_op2_d   = out_op2_q;
    out_rd_d    = out_rd_q;
    out_rd_we_d = out_rd_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_op1_d   = op1_sel;
      out_op2_d   = op2_sel;
      out_rd_d    = in_rd;
      out_rd_we_d = in_rd_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (in_valid && !in_ready && (stall_cnt_q != {STALL_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_op1_q   <= '0;
      out_op2_q   <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_op1_q   <= out_op1_d;
      out_op2_q   <= out_op2_d;
      out_rd_q    <= out_rd_d;
      out_rd_we_q <= out_rd_we_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd    = out_rd_q;
  assign out_rd_we = out_rd_we_q;
  assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - table and random checks of operand_fetch against a model
module tb_operand_fetch;
  localparam int XLEN    = 32;
  localparam int AW      = 5;
  localparam int STALL_W = 6;
  localparam int SMAX    = 63;
  localparam int NTAB    = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, in_rd_we;
  logic [AW-1:0]   in_rs1, in_rs2, in_rd;
  logic [AW-1:0]   rf_raddr1, rf_raddr2;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;
  logic            wb_we;
  logic [AW-1:0]   wb_waddr;
  logic [XLEN-1:0] wb_wdata;
  logic            out_valid, out_ready, out_rd_we;
  logic [XLEN-1:0] out_op1, out_op2;
  logic [AW-1:0]   out_rd;
  logic [STALL_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  // Environment register file; entry 0 holds garbage so x0 forcing is always exercised.
  logic [XLEN-1:0] rf_mem [32];
  assign rf_rdata1 = rf_mem[rf_raddr1];
  assign rf_rdata2 = rf_mem[rf_raddr2];

  operand_fetch #(.XLEN(XLEN), .AW(AW), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_we(in_rd_we),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2),
    .out_rd(out_rd), .out_rd_we(out_rd_we),
    .stall_cnt(stall_cnt)
  );

  // Reference model: architectural register values, set of registers awaiting writeback,
  // and the contents of the output slot.
  logic [XLEN-1:0] arch [32];
  bit              pend_m [32];
  logic            ov_m;
  logic [XLEN-1:0] op1_m, op2_m;
  logic [AW-1:0]   rd_m;
  logic            rdwe_m;
  int              stall_m;
  int              n_pass = 0;
  int              n_total = 0;

  typedef struct {
    logic iv; logic [4:0] rs1, rs2, rd; logic rdwe, wbwe; logic [4:0] wba;
    logic [31:0] wbd; logic ordy;
    logic e_rdy, e_ov; logic [31:0] e_op1, e_op2; int e_stall;
  } vec_t;
  vec_t tbl [NTAB];

  function automatic vec_t mk(input logic iv, input logic [4:0] rs1, rs2, rd, input logic rdwe,
                              input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                              input logic ordy, input logic e_rdy, input logic e_ov,
                              input logic [31:0] e_op1, e_op2, input int e_stall);
    vec_t v;
    v.iv = iv; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rdwe = rdwe; v.wbwe = wbwe;
    v.wba = wba; v.wbd = wbd; v.ordy = ordy; v.e_rdy = e_rdy; v.e_ov = e_ov;
    v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_stall = e_stall;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend_m[i] = 0;
    ov_m = 0; op1_m = '0; op2_m = '0; rd_m = '0; rdwe_m = 0; stall_m = 0;
  endtask

  function automatic bit busy(input logic [4:0] r, input logic wbwe, input logic [4:0] wba);
    return pend_m[r] && !(wbwe && wba == r);
  endfunction

  task automatic drive_idle();
    in_valid = 0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 0;
    wb_we = 0; wb_waddr = '0; wb_wdata = '0; out_ready = 0;
  endtask

  // Called just after an active edge; drives one cycle, checks in_ready, then post-edge state.
  task automatic cycle(input logic iv, input logic [4:0] rs1, rs2, rd, input logic rdwe,
                       input logic wbwe, input logic [4:0] wba, input logic [31:0] wbd,
                       input logic ordy, output logic rdy_seen);
    logic            rdy_m, acc;
    logic [XLEN-1:0] nxt [32];
    in_valid = iv; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = rdwe;
    wb_we = wbwe; wb_waddr = wba; wb_wdata = wbd; out_ready = ordy;
    #2;
    rdy_m = !(busy(rs1, wbwe, wba) || busy(rs2, wbwe, wba) || (rdwe && busy(rd, wbwe, wba)))
            && (!ov_m || ordy);
    rdy_seen = in_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy_m});
    acc = iv && rdy_m;
    nxt = arch;
    if (wbwe && wba != 0) nxt[wba] = wbd;
    if (acc) begin
      op1_m = nxt[rs1]; op2_m = nxt[rs2]; rd_m = rd; rdwe_m = rdwe; ov_m = 1;
    end else if (ordy) begin
      ov_m = 0;
    end
    if (wbwe) pend_m[wba] = 0;
    if (acc && rdwe && rd != 0) pend_m[rd] = 1;
    if (iv && !rdy_m && stall_m < SMAX) stall_m++;
    arch = nxt;
    @(posedge clk);
    #1;
    if (wbwe && wba != 0) rf_mem[wba] = wbd;
    chk("out_valid", {31'b0, out_valid}, {31'b0, ov_m});
    chk("out_op1", out_op1, op1_m);
    chk("out_op2", out_op2, op2_m);
    chk("out_rd", 32'(out_rd), 32'(rd_m));
    chk("out_rd_we", {31'b0, out_rd_we}, {31'b0, rdwe_m});
    chk("stall_cnt", 32'(stall_cnt), 32'(stall_m));
  endtask

  initial begin
    logic rdy;
    rst = 1'b1;
    drive_idle();
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'hA000_0000 | i;
    rf_mem[5] = 32'h11;
    rf_mem[6] = 32'h22;
    rf_mem[0] = 32'hFFFF_FFFF;
    arch = rf_mem;
    arch[0] = '0;
    model_reset();

    //            iv rs1 rs2 rd we wbe wba wbd        ordy rdy ov op1           op2           stall
    tbl[0]  = mk(1, 5,  6,  10, 0, 0, 0, 0,          1,   1,  1, 32'h11,       32'h22,       0);
    tbl[1]  = mk(1, 0,  5,  0,  1, 0, 0, 0,          1,   1,  1, 32'h0,        32'h11,       0);
    tbl[2]  = mk(1, 0,  0,  1,  0, 0, 0, 0,          1,   1,  1, 32'h0,        32'h0,        0);
    tbl[3]  = mk(1, 1,  2,  7,  1, 0, 0, 0,          1,   1,  1, 32'hA0000001, 32'hA0000002, 0);
    tbl[4]  = mk(1, 7,  0,  8,  0, 0, 0, 0,          1,   0,  0, 32'hA0000001, 32'hA0000002, 1);
    tbl[5]  = mk(1, 7,  0,  8,  0, 0, 0, 0,          1,   0,  0, 32'hA0000001, 32'hA0000002, 2);
    tbl[6]  = mk(1, 7,  0,  8,  0, 0, 0, 0,          1,   0,  0, 32'hA0000001, 32'hA0000002, 3);
    tbl[7]  = mk(1, 7,  0,  8,  0, 1, 7, 32'hDEAD,   1,   1,  1, 32'hDEAD,     32'h0,        3);
    tbl[8]  = mk(1, 5,  6,  0,  0, 0, 0, 0,          1,   1,  1, 32'h11,       32'h22,       3);
    tbl[9]  = mk(1, 6,  5,  3,  0, 0, 0, 0,          0,   0,  1, 32'h11,       32'h22,       4);
    tbl[10] = mk(1, 6,  5,  3,  0, 0, 0, 0,          0,   0,  1, 32'h11,       32'h22,       5);
    tbl[11] = mk(1, 6,  5,  3,  0, 0, 0, 0,          0,   0,  1, 32'h11,       32'h22,       6);
    tbl[12] = mk(1, 6,  5,  3,  0, 0, 0, 0,          0,   0,  1, 32'h11,       32'h22,       7);
    tbl[13] = mk(1, 6,  5,  3,  0, 0, 0, 0,          1,   1,  1, 32'h22,       32'h11,       7);
    tbl[14] = mk(1, 0,  0,  9,  1, 0, 0, 0,          1,   1,  1, 32'h0,        32'h0,        7);
    tbl[15] = mk(1, 0,  0,  9,  1, 0, 0, 0,          1,   0,  0, 32'h0,        32'h0,        8);
    tbl[16] = mk(1, 0,  0,  9,  1, 1, 9, 32'h99,     1,   1,  1, 32'h0,        32'h0,        8);
    tbl[17] = mk(1, 9,  0,  4,  0, 0, 0, 0,          1,   0,  0, 32'h0,        32'h0,        9);
    tbl[18] = mk(1, 9,  0,  4,  0, 1, 9, 32'h1234,   1,   1,  1, 32'h1234,     32'h0,        9);
    tbl[19] = mk(1, 0,  0,  3,  1, 0, 0, 0,          1,   1,  1, 32'h0,        32'h0,        9);

    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_op1", out_op1, 32'h0);
    chk("rst_out_op2", out_op2, 32'h0);
    chk("rst_out_rd", 32'(out_rd), 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NTAB; i++) begin
      cycle(tbl[i].iv, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rdwe, tbl[i].wbwe,
            tbl[i].wba, tbl[i].wbd, tbl[i].ordy, rdy);
      chk($sformatf("tab%0d_rdy", i), {31'b0, rdy}, {31'b0, tbl[i].e_rdy});
      chk($sformatf("tab%0d_ov", i), {31'b0, out_valid}, {31'b0, tbl[i].e_ov});
      chk($sformatf("tab%0d_op1", i), out_op1, tbl[i].e_op1);
      chk($sformatf("tab%0d_op2", i), out_op2, tbl[i].e_op2);
      chk($sformatf("tab%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].e_stall));
    end

    // Asynchronous reset between edges with a held output and x3 pending.
    drive_idle();
    chk("pre_rst_ov", {31'b0, out_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ov", {31'b0, out_valid}, 32'h0);
    chk("async_rst_stall", 32'(stall_cnt), 32'h0);
    chk("async_rst_op1", out_op1, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1, 3, 0, 5, 0, 0, 0, 0, 1, rdy);
    chk("post_rst_rs3_rdy", {31'b0, rdy}, 32'h1);
    chk("post_rst_rs3_op1", out_op1, 32'hA0000003);

    for (int n = 0; n < 600; n++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 15));
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
            5'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            wa, $urandom, ($urandom_range(0, 3) != 0), rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
